// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, valid/ready
// handshake on operands and result, divide-by-zero flagged with an all-ones quotient.
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [DIVIDEND_W-1:0] q_r, q_s;
    logic [DIVISOR_W-1:0]  r_r, r_s;
    logic [DIVISOR_W-1:0]  d_r, d_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  in_ready_r, in_ready_s;
    logic                  out_valid_r, out_valid_s;
    logic [DIVIDEND_W-1:0] quotient_r, quotient_s;
    logic [DIVISOR_W-1:0]  remainder_r, remainder_s;
    logic                  dbz_r, dbz_s;

    logic [DIVISOR_W:0]    r_shift_s;
    logic [DIVISOR_W-1:0]  r_iter_s;
    logic [DIVIDEND_W-1:0] q_iter_s;
    logic                  q_bit_s;

    // One restoring step; the kept remainder is always below the divisor so it fits DIVISOR_W bits.
    always_comb begin
        r_shift_s = {r_r, q_r[DIVIDEND_W-1]};
        q_bit_s   = (r_shift_s >= {1'b0, d_r});
        if (q_bit_s) begin
            r_iter_s = r_shift_s[DIVISOR_W-1:0] - d_r;
        end else begin
            r_iter_s = r_shift_s[DIVISOR_W-1:0];
        end
        q_iter_s = {q_r[DIVIDEND_W-2:0], q_bit_s};
    end

    // Next-state and next-register logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_s     = state_r;
        q_s         = q_r;
        r_s         = r_r;
        d_s         = d_r;
        cnt_s       = cnt_r;
        out_valid_s = out_valid_r;
        quotient_s  = quotient_r;
        remainder_s = remainder_r;
        dbz_s       = dbz_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    d_s = divisor;
                    q_s = dividend;
                    if (divisor != {DIVISOR_W{1'b0}}) begin
                        r_s     = {DIVISOR_W{1'b0}};
                        cnt_s   = CNT_LAST;
                        dbz_s   = 1'b0;
                        state_s = CALC;
                    end else begin
                        quotient_s  = {DIVIDEND_W{1'b1}};
                        remainder_s = {DIVISOR_W{1'b0}};
                        dbz_s       = 1'b1;
                        state_s     = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                q_s = q_iter_s;
                r_s = r_iter_s;
                if (cnt_r == {CNT_W{1'b0}}) begin
                    quotient_s  = q_iter_s;
                    remainder_s = r_iter_s;
                    state_s     = DONE;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                // out_valid rises one clock after entering DONE, so results are settled first.
                if (out_valid_r && out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                state_s     = IDLE;
            end
        endcase
        in_ready_s = (state_s == IDLE);
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            q_r         <= {DIVIDEND_W{1'b0}};
            r_r         <= {DIVISOR_W{1'b0}};
            d_r         <= {DIVISOR_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= {DIVIDEND_W{1'b0}};
            remainder_r <= {DIVISOR_W{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            q_r         <= q_s;
            r_r         <= r_s;
            d_r         <= d_s;
            cnt_r       <= cnt_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            quotient_r  <= quotient_s;
            remainder_r <= remainder_s;
            dbz_r       <= dbz_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: vector table, backpressure,
// mid-operation reset and randomized operands, all through a result scoreboard.
module tb_seq_restoring_divider;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    exp_t vecs[8];
    int   compared   = 0;
    int   mismatched = 0;

    seq_restoring_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] a, input logic [7:0] b,
                                input logic [15:0] q, input logic [7:0] r, input logic dbz);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer an operand pair after 'gap' idle cycles; push its expected result once accepted.
    task automatic send(input exp_t e, input int gap);
        int cyc;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        dividend = e.a;
        divisor  = e.b;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("accept_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(e);
    endtask

    // Wait for the result, optionally stall it with in_valid noise, then pop and compare.
    task automatic collect(input int hold);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("latency", cyc, e.dbz ? 32'd1 : 32'd17);
            for (int i = 0; i < hold; i++) begin
                in_valid = i[0];
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
                @(posedge clk); #1;
                check("hold_out_valid", {31'd0, out_valid}, 32'd1);
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
                check("hold_quotient", {16'd0, quotient}, {16'd0, e.q});
                check("hold_remainder", {24'd0, remainder}, {24'd0, e.r});
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("quotient", {16'd0, quotient}, {16'd0, e.q});
            check("remainder", {24'd0, remainder}, {24'd0, e.r});
            check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            if (e.dbz == 1'b0 && quotient < 16'd256) begin
                check("mul_invariant", 32'(quotient[7:0]) * 32'(e.b) + 32'(remainder), 32'(e.a));
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
            check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        exp_t e;
        logic [15:0] ra;
        logic [7:0]  rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 16'd0;
        divisor   = 8'd0;

        vecs[0] = mk(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0);
        vecs[1] = mk(16'd1000, 8'd7,  16'h008E, 8'd6,  1'b0);
        vecs[2] = mk(16'h0000, 8'h05, 16'h0000, 8'h00, 1'b0);
        vecs[3] = mk(16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1);
        vecs[4] = mk(16'h0010, 8'h03, 16'h0005, 8'h01, 1'b0);
        vecs[5] = mk(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0);
        vecs[6] = mk(16'h0007, 8'h09, 16'h0000, 8'h07, 1'b0);
        vecs[7] = mk(16'h00FE, 8'hFF, 16'h0000, 8'hFE, 1'b0);

        #23;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i], i % 2);
            collect(0);
        end

        // Backpressure: 10 stalled cycles with in_valid pulses that must be ignored.
        send(mk(16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0), 0);
        collect(10);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_spurious_result", {31'd0, out_valid}, 32'd0);
        end

        // Reset at iteration 8 discards the operation.
        send(mk(16'h8000, 8'h03, 16'h2AAA, 8'h02, 1'b0), 0);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_quotient", {16'd0, quotient}, 32'd0);
        check("midrst_remainder", {24'd0, remainder}, 32'd0);
        check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("discarded_no_result", {31'd0, out_valid}, 32'd0);
        end
        send(mk(16'h8000, 8'h03, 16'h2AAA, 8'h02, 1'b0), 0);
        collect(0);

        // Random operands against a behavioural division model.
        for (int n = 0; n < 2500; n++) begin
            ra = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) begin
                ra = 16'($urandom_range(0, 300));
            end
            rb = 8'($urandom_range(1, 255));
            e  = mk(ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0);
            send(e, int'($urandom_range(0, 2)));
            collect(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
